// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between two requesters.
// A single read is in flight at a time: IDLE (grant) -> WAIT (ROM latency) -> RESP (hand back).
module rom_read_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; valid must not depend on ready.

  localparam int CNT_W = $clog2(ROM_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               last_grant;
  logic               owner;
  logic [CNT_W-1:0]   cnt;
  logic               win0, win1;
  logic               accept;
  logic               capture;
  logic               rsp_done;

  // On a tie the requester that was not served last wins.
  assign win0 = req0_valid & (~req1_valid | last_grant);
  assign win1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = (state == S_IDLE) & win0;
  assign req1_ready = (state == S_IDLE) & win1;

  assign accept   = (state == S_IDLE) & (win0 | win1);
  // rom_addr is registered at accept, so the ROM samples it one edge later; the
  // data is therefore ready ROM_LAT+1 edges after accept, i.e. when cnt has run out.
  assign capture  = (state == S_WAIT) & (cnt == '0);
  assign rsp_done = (state == S_RESP) & (owner ? rsp1_ready : rsp0_ready);

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_WAIT;
      S_WAIT:  if (capture)  state_nxt = S_RESP;
      S_RESP:  if (rsp_done) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      rom_addr   <= win1 ? req1_addr : req0_addr;
      last_grant <= win1;
      owner      <= win1;
      cnt        <= CNT_W'(ROM_LAT);
    end else if ((state == S_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Response registers: only the owning channel is touched; data holds after valid falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
    end else begin
      if (capture) begin
        if (owner) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= rom_data;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= rom_data;
        end
      end
      if (rsp_done) begin
        if (owner) rsp1_valid <= 1'b0;
        else       rsp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomized bench for rom_read_arbiter: a transaction-level model predicts grants,
// response timing and data; a ROM_LAT=2 instance checks the longer latency path.
module tb_rom_read_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int LAT    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [ADDR_W-1:0] req0_addr = 0, req1_addr = 0;
  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [DATA_W-1:0] rsp0_data, rsp1_data, rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        state_dbg;

  logic              d2_req1_valid = 0;
  logic [ADDR_W-1:0] d2_req1_addr = 0;
  logic              d2_req0_ready, d2_req1_ready, d2_rsp0_valid, d2_rsp1_valid, d2_busy;
  logic [DATA_W-1:0] d2_rsp0_data, d2_rsp1_data, d2_rom_data;
  logic [ADDR_W-1:0] d2_rom_addr;
  logic [1:0]        d2_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rom_q, rom2_a, rom2_b;

  always @(posedge clk) begin
    rom_q  <= rom_mem[rom_addr];
    rom2_a <= rom_mem[d2_rom_addr];
    rom2_b <= rom2_a;
  end
  assign rom_data    = rom_q;
  assign d2_rom_data = rom2_b;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .state_dbg(state_dbg)
  );

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(1'b0), .req0_addr('0), .req0_ready(d2_req0_ready),
    .rsp0_valid(d2_rsp0_valid), .rsp0_data(d2_rsp0_data), .rsp0_ready(1'b1),
    .req1_valid(d2_req1_valid), .req1_addr(d2_req1_addr), .req1_ready(d2_req1_ready),
    .rsp1_valid(d2_rsp1_valid), .rsp1_data(d2_rsp1_data), .rsp1_ready(1'b1),
    .rom_addr(d2_rom_addr), .rom_data(d2_rom_data), .busy(d2_busy), .state_dbg(d2_state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // Transaction view: free -> waiting (ROM_LAT+1 cycles) -> responding (until taken).
  logic [DATA_W-1:0] exp_q[$];
  int                m_phase;
  int                m_wait;
  logic              m_last;
  logic              m_owner;
  logic [ADDR_W-1:0] m_rom_addr;
  logic [DATA_W-1:0] m_data0, m_data1;
  logic              e_r0, e_r1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_last = 1'b1; m_owner = 1'b0;
      m_rom_addr = '0; m_data0 = '0; m_data1 = '0;
      exp_q.delete();
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", {req0_ready, req1_ready}, 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
    end else begin
      e_r0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
      e_r1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("busy", busy, m_phase != 0);
      chk("rsp0_valid", rsp0_valid, (m_phase == 2) && !m_owner);
      chk("rsp1_valid", rsp1_valid, (m_phase == 2) && m_owner);
      chk("rsp0_data", rsp0_data, m_data0);
      chk("rsp1_data", rsp1_data, m_data1);
      chk("rom_addr", rom_addr, m_rom_addr);
      case (m_phase)
        0: if (e_r0 || e_r1) begin
             m_owner    = e_r1;
             m_last     = e_r1;
             m_rom_addr = e_r1 ? req1_addr : req0_addr;
             exp_q.push_back(rom_mem[m_rom_addr]);
             m_wait     = LAT + 1;
             m_phase    = 1;
           end
        1: begin
             m_wait--;
             if (m_wait == 0) begin
               m_phase = 2;
               if (exp_q.size() == 0) begin
                 chk("exp_q_underflow", 1, 0);
               end else if (m_owner) begin
                 m_data1 = exp_q.pop_front();
               end else begin
                 m_data0 = exp_q.pop_front();
               end
             end
           end
        default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_addr = 0; req1_addr = 0;
  endtask

  int lat_cnt;
  bit seen;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    rom_mem[0]  = 16'h5601;
    rom_mem[1]  = 16'h3401;
    rom_mem[15] = 16'h5401;

    // reset with all inputs low
    rst_n = 0;
    repeat (3) cycle();
    rst_n = 1;
    cycle();

    // single read from requester 0, response taken immediately
    req0_valid = 1; req0_addr = 4'h0; rsp0_ready = 1;
    cycle();
    req0_valid = 0;
    repeat (5) cycle();

    // both requesters held valid: grants must alternate
    req0_valid = 1; req0_addr = 4'h1; req1_valid = 1; req1_addr = 4'hF;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (24) cycle();
    idle_inputs();
    cycle();

    // requester 0 stalls its response while requester 1 waits
    req0_valid = 1; req0_addr = 4'hF;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = req0_ready;
      cycle();
    end
    chk("stall_accept_seen", seen, 1);
    req0_valid = 0; req1_valid = 1; req1_addr = 4'h1;
    repeat (7) cycle();
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (8) cycle();
    idle_inputs();
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_addr  = ADDR_W'($urandom);
      req1_addr  = ADDR_W'($urandom);
      rsp0_ready = ($urandom_range(0, 99) < 70);
      rsp1_ready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    idle_inputs();
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (6) cycle();
    idle_inputs();

    // ROM_LAT=2 instance: response three cycles after accept
    d2_req1_valid = 1; d2_req1_addr = 4'h1;
    @(negedge clk);
    chk("lat2_req1_ready", d2_req1_ready, 1);
    cycle();
    d2_req1_valid = 0;
    lat_cnt = 0;
    seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (d2_rsp1_valid) begin
        seen = 1;
        lat_cnt = k - 1;
      end
    end
    chk("lat2_rsp_seen", seen, 1);
    chk("lat2_latency", lat_cnt, 3);
    chk("lat2_rsp1_data", d2_rsp1_data, 16'h3401);
    repeat (3) cycle();

    // reset while a read is in WAIT: no response may appear
    req0_valid = 1; req0_addr = 4'hF; rsp0_ready = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = req0_ready;
      cycle();
    end
    chk("midwait_accept_seen", seen, 1);
    req0_valid = 0;
    chk("midwait_busy", busy, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
